// File: rtl/control_unit.sv
// Multi-cycle processor control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// and decodes the IR into the data-path CTRL bus and memory strobes.
module control_unit #(
    parameter int CTRL_W = 32,
    parameter int OPRN_W = 6
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [31:0]       INSTRUCTION,
    input  logic              ZERO,
    output logic [CTRL_W-1:0] CTRL,
    output logic              READ,
    output logic              WRITE
);

    localparam int PC_LOAD  = 0;
    localparam int PC_SEL_1 = 1;
    localparam int PC_SEL_2 = 2;
    localparam int PC_SEL_3 = 3;
    localparam int IR_LOAD  = 4;
    localparam int R1_SEL_1 = 5;
    localparam int REG_R    = 6;
    localparam int REG_W    = 7;
    localparam int SP_LOAD  = 8;
    localparam int MA_SEL_1 = 20;
    localparam int MA_SEL_2 = 21;
    localparam int MD_SEL_1 = 22;
    localparam int MEM_R    = 29;
    localparam int MEM_W    = 30;

    localparam logic [OPRN_W-1:0] ALU_ADD = 6'd1;
    localparam logic [OPRN_W-1:0] ALU_SUB = 6'd2;
    localparam logic [OPRN_W-1:0] ALU_MUL = 6'd3;
    localparam logic [OPRN_W-1:0] ALU_SRL = 6'd4;
    localparam logic [OPRN_W-1:0] ALU_SLL = 6'd5;
    localparam logic [OPRN_W-1:0] ALU_AND = 6'd6;
    localparam logic [OPRN_W-1:0] ALU_OR  = 6'd7;
    localparam logic [OPRN_W-1:0] ALU_NOR = 6'd8;
    localparam logic [OPRN_W-1:0] ALU_SLT = 6'd9;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [5:0]        opcode_s;
    logic [5:0]        funct_s;
    logic [OPRN_W-1:0] alu_s;
    logic [3:0]        op2_sel_s;
    logic [2:0]        wd_sel_s;
    logic [2:0]        wa_sel_s;
    logic              op1_sel_s;
    logic              reg_wr_s;
    logic              rtype_s;
    logic              is_lw_s;
    logic              is_sw_s;
    logic              is_push_s;
    logic              is_pop_s;
    logic              is_jr_s;
    logic              is_jump_s;
    logic              is_beq_s;
    logic              is_bne_s;
    logic              taken_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic              unused_bits_s;

    assign opcode_s      = INSTRUCTION[31:26];
    assign funct_s       = INSTRUCTION[5:0];
    assign unused_bits_s = ^INSTRUCTION[25:6];

    // Operand selects and ALU code shared by EXECUTE, MEMORY and WRITEBACK.
    function automatic logic [CTRL_W-1:0] exec_fields(input logic op1,
                                                      input logic [3:0] op2,
                                                      input logic [OPRN_W-1:0] alu);
        logic [CTRL_W-1:0] f;
        f             = '0;
        f[9]          = op1;
        f[13:10]      = op2;
        f[14+:OPRN_W] = alu;
        return f;
    endfunction

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Fixed five-state instruction sequence.
    always_comb begin
        state_next_s = IDLE;
        case (state_r)
            IDLE:      state_next_s = FETCH;
            FETCH:     state_next_s = DECODE;
            DECODE:    state_next_s = EXECUTE;
            EXECUTE:   state_next_s = MEMORY;
            MEMORY:    state_next_s = WRITEBACK;
            WRITEBACK: state_next_s = FETCH;
            default:   state_next_s = IDLE;
        endcase
    end

    // Instruction classification; anything unrecognised falls through as a NOP.
    always_comb begin
        alu_s     = '0;
        op1_sel_s = 1'b0;
        op2_sel_s = 4'b0000;
        wd_sel_s  = 3'b000;
        wa_sel_s  = 3'b000;
        reg_wr_s  = 1'b0;
        rtype_s   = 1'b0;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
        is_push_s = 1'b0;
        is_pop_s  = 1'b0;
        is_jr_s   = 1'b0;
        is_jump_s = 1'b0;
        is_beq_s  = 1'b0;
        is_bne_s  = 1'b0;
        case (opcode_s)
            6'h00: begin
                // op2_sel_4 = rt data, op2_sel_3 = shift amount
                case (funct_s)
                    6'h20: begin alu_s = ALU_ADD; op2_sel_s = 4'b1000; rtype_s = 1'b1; end
                    6'h22: begin alu_s = ALU_SUB; op2_sel_s = 4'b1000; rtype_s = 1'b1; end
                    6'h2c: begin alu_s = ALU_MUL; op2_sel_s = 4'b1000; rtype_s = 1'b1; end
                    6'h24: begin alu_s = ALU_AND; op2_sel_s = 4'b1000; rtype_s = 1'b1; end
                    6'h25: begin alu_s = ALU_OR;  op2_sel_s = 4'b1000; rtype_s = 1'b1; end
                    6'h27: begin alu_s = ALU_NOR; op2_sel_s = 4'b1000; rtype_s = 1'b1; end
                    6'h2a: begin alu_s = ALU_SLT; op2_sel_s = 4'b1000; rtype_s = 1'b1; end
                    6'h01: begin alu_s = ALU_SLL; op2_sel_s = 4'b0100; rtype_s = 1'b1; end
                    6'h02: begin alu_s = ALU_SRL; op2_sel_s = 4'b0100; rtype_s = 1'b1; end
                    6'h08: is_jr_s = 1'b1;
                    default: rtype_s = 1'b0;
                endcase
                reg_wr_s = rtype_s;
                wa_sel_s = {2'b00, rtype_s};
            end
            6'h08: begin alu_s = ALU_ADD; op2_sel_s = 4'b0010; reg_wr_s = 1'b1; end
            6'h1d: begin alu_s = ALU_MUL; op2_sel_s = 4'b0010; reg_wr_s = 1'b1; end
            6'h0c: begin alu_s = ALU_AND; op2_sel_s = 4'b0010; reg_wr_s = 1'b1; end
            6'h0d: begin alu_s = ALU_OR;  op2_sel_s = 4'b0010; reg_wr_s = 1'b1; end
            6'h0a: begin alu_s = ALU_SLT; op2_sel_s = 4'b0010; reg_wr_s = 1'b1; end
            6'h0f: begin alu_s = ALU_SLL; op2_sel_s = 4'b0010; reg_wr_s = 1'b1; wd_sel_s = 3'b100; end
            6'h04: begin alu_s = ALU_SUB; op2_sel_s = 4'b1000; is_beq_s = 1'b1; end
            6'h05: begin alu_s = ALU_SUB; op2_sel_s = 4'b1000; is_bne_s = 1'b1; end
            6'h23: begin alu_s = ALU_ADD; op2_sel_s = 4'b0010; is_lw_s = 1'b1; reg_wr_s = 1'b1; wd_sel_s = 3'b001; end
            6'h2b: begin alu_s = ALU_ADD; op2_sel_s = 4'b0010; is_sw_s = 1'b1; end
            6'h02: is_jump_s = 1'b1;
            6'h03: begin is_jump_s = 1'b1; reg_wr_s = 1'b1; wd_sel_s = 3'b010; wa_sel_s = 3'b100; end
            // Stack ops: operand 1 is SP, operand 2 the constant one.
            6'h1b: begin alu_s = ALU_SUB; op1_sel_s = 1'b1; op2_sel_s = 4'b0001; is_push_s = 1'b1; end
            6'h1c: begin
                alu_s = ALU_ADD; op1_sel_s = 1'b1; op2_sel_s = 4'b0001;
                is_pop_s = 1'b1; reg_wr_s = 1'b1; wd_sel_s = 3'b001;
            end
            default: reg_wr_s = 1'b0;
        endcase
    end

    assign taken_s = (is_beq_s & ZERO) | (is_bne_s & ~ZERO);

    // Moore decode of state plus instruction onto the CTRL bus.
    always_comb begin
        ctrl_s = '0;
        case (state_r)
            IDLE: ctrl_s = '0;
            FETCH: begin
                ctrl_s[MEM_R]    = 1'b1;
                ctrl_s[MA_SEL_2] = 1'b1;
                ctrl_s[IR_LOAD]  = 1'b1;
            end
            DECODE: begin
                ctrl_s[REG_R]    = 1'b1;
                ctrl_s[R1_SEL_1] = is_pop_s;
            end
            EXECUTE: ctrl_s = exec_fields(op1_sel_s, op2_sel_s, alu_s);
            MEMORY: begin
                ctrl_s           = exec_fields(op1_sel_s, op2_sel_s, alu_s);
                ctrl_s[MEM_R]    = is_lw_s | is_pop_s;
                ctrl_s[MEM_W]    = is_sw_s | is_push_s;
                ctrl_s[MD_SEL_1] = is_sw_s | is_push_s;
                ctrl_s[MA_SEL_1] = is_pop_s;
            end
            WRITEBACK: begin
                ctrl_s           = exec_fields(op1_sel_s, op2_sel_s, alu_s);
                ctrl_s[PC_LOAD]  = 1'b1;
                ctrl_s[PC_SEL_1] = ~is_jr_s;
                ctrl_s[PC_SEL_2] = taken_s;
                ctrl_s[PC_SEL_3] = ~is_jump_s;
                ctrl_s[REG_W]    = reg_wr_s;
                ctrl_s[SP_LOAD]  = is_push_s | is_pop_s;
                ctrl_s[25:23]    = reg_wr_s ? wd_sel_s : 3'b000;
                ctrl_s[28:26]    = reg_wr_s ? wa_sel_s : 3'b000;
            end
            default: ctrl_s = '0;
        endcase
        ctrl_s[CTRL_W-1] = 1'b0;
    end

    assign CTRL  = ctrl_s;
    assign READ  = ctrl_s[MEM_R];
    assign WRITE = ctrl_s[MEM_W];

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, randomized
// instructions against a mnemonic-level reference model, and reset corner cases.
module tb_control_unit;

    logic        CLK;
    logic        RST;
    logic [31:0] INSTRUCTION;
    logic        ZERO;
    logic [31:0] CTRL;
    logic        READ;
    logic        WRITE;

    int n_cmp = 0;
    int n_bad = 0;
    int alu_of[string];
    bit writes_reg[string];
    logic [31:0] obs [6];

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic        chk_alu;
        logic [5:0]  alu;
        logic [1:0]  mem;   // {write, read} in MEMORY
        logic [8:0]  wb;    // CTRL[8:0] in WRITEBACK
    } vec_t;

    vec_t       tbl [16];
    logic [5:0] rfun [10];
    logic [5:0] iop  [14];

    control_unit #(.CTRL_W(32), .OPRN_W(6)) dut (
        .CLK(CLK), .RST(RST), .INSTRUCTION(INSTRUCTION), .ZERO(ZERO),
        .CTRL(CTRL), .READ(READ), .WRITE(WRITE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic string mnem(input logic [31:0] ins);
        logic [5:0] op = ins[31:26];
        logic [5:0] fn = ins[5:0];
        if (op == 6'h00) begin
            case (fn)
                6'h20: return "add";  6'h22: return "sub";  6'h2c: return "mul";
                6'h24: return "and";  6'h25: return "or";   6'h27: return "nor";
                6'h2a: return "slt";  6'h01: return "sll";  6'h02: return "srl";
                6'h08: return "jr";
                default: return "nop";
            endcase
        end
        case (op)
            6'h08: return "addi"; 6'h1d: return "muli"; 6'h0c: return "andi";
            6'h0d: return "ori";  6'h0f: return "lui";  6'h0a: return "slti";
            6'h04: return "beq";  6'h05: return "bne";  6'h23: return "lw";
            6'h2b: return "sw";   6'h02: return "jmp";  6'h03: return "jal";
            6'h1b: return "push"; 6'h1c: return "pop";
            default: return "nop";
        endcase
    endfunction

    // ph: 0 idle, 1 fetch, 2 decode, 3 execute, 4 memory, 5 writeback
    function automatic void model(input int ph, input logic [31:0] ins, input logic z,
                                  output logic [31:0] e, output logic [31:0] m);
        string nm;
        nm = mnem(ins);
        e  = 32'h0;
        m  = 32'hE02001FF;
        case (ph)
            0: m = 32'hFFFFFFFF;
            1: begin m = 32'hFFFFFFFF; e = 32'h20200010; end
            2: begin m = 32'hFFFFFFFF; e[6] = 1'b1; e[5] = (nm == "pop"); end
            default: begin
                if (alu_of.exists(nm)) begin
                    m[19:14] = 6'h3F;
                    e[19:14] = 6'(alu_of[nm]);
                end
                if (ph == 4) begin
                    e[29] = (nm == "lw") || (nm == "pop");
                    if ((nm == "sw") || (nm == "push")) begin
                        e[30] = 1'b1; e[22] = 1'b1; m[22] = 1'b1;
                    end
                end
                if (ph == 5) begin
                    e[0] = 1'b1;
                    e[1] = (nm != "jr");
                    e[2] = ((nm == "beq") && z) || ((nm == "bne") && !z);
                    e[3] = !((nm == "jmp") || (nm == "jal"));
                    e[7] = writes_reg.exists(nm);
                    e[8] = (nm == "push") || (nm == "pop");
                    if (nm == "nop") m = 32'hFFFFFFFF;
                end
            end
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp, input logic [31:0] msk);
        n_cmp++;
        if ((got & msk) !== (exp & msk)) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (mask %h) t=%0t", nm, got, exp, msk, $time);
        end
    endtask

    task automatic check_phase(input int ph, input logic [31:0] ins, input logic z);
        logic [31:0] e;
        logic [31:0] m;
        model(ph, ins, z, e, m);
        check($sformatf("ctrl ph%0d %s ins=%h", ph, mnem(ins), ins), CTRL, e, m);
        check("read strobe",  {31'h0, READ},  {31'h0, e[29]}, 32'h1);
        check("write strobe", {31'h0, WRITE}, {31'h0, e[30]}, 32'h1);
        obs[ph] = CTRL;
    endtask

    // Entered 1 time unit after the edge into FETCH; returns at the same point
    // of the following FETCH. INSTRUCTION plays the IR, loaded as DECODE begins.
    task automatic run_instr(input logic [31:0] ins, input logic z);
        INSTRUCTION = $urandom;
        ZERO = 1'($urandom_range(0, 1));
        #1 check_phase(1, ins, z);
        for (int ph = 2; ph <= 5; ph++) begin
            @(posedge CLK); #1;
            if (ph == 2) INSTRUCTION = ins;
            ZERO = (ph == 5) ? z : 1'($urandom_range(0, 1));
            #1 check_phase(ph, ins, z);
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] ins;
        RST = 1'b1;
        INSTRUCTION = 32'h0;
        ZERO = 1'b0;

        alu_of["add"] = 1;  alu_of["sub"] = 2;  alu_of["mul"] = 3;  alu_of["srl"] = 4;
        alu_of["sll"] = 5;  alu_of["and"] = 6;  alu_of["or"] = 7;   alu_of["nor"] = 8;
        alu_of["slt"] = 9;  alu_of["addi"] = 1; alu_of["muli"] = 3; alu_of["andi"] = 6;
        alu_of["ori"] = 7;  alu_of["slti"] = 9; alu_of["beq"] = 2;  alu_of["bne"] = 2;
        alu_of["lw"] = 1;   alu_of["sw"] = 1;   alu_of["nop"] = 0;
        foreach (alu_of[k]) if ((k != "beq") && (k != "bne") && (k != "sw") && (k != "nop")) writes_reg[k] = 1'b1;
        writes_reg["lui"] = 1'b1; writes_reg["pop"] = 1'b1; writes_reg["jal"] = 1'b1;

        rfun = '{6'h20, 6'h22, 6'h2c, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h01, 6'h02, 6'h08};
        iop  = '{6'h08, 6'h1d, 6'h0c, 6'h0d, 6'h0f, 6'h0a, 6'h04, 6'h05,
                 6'h23, 6'h2b, 6'h02, 6'h03, 6'h1b, 6'h1c};

        tbl[0]  = '{32'h00430820, 1'b0, 1'b1, 6'd1, 2'b00, 9'h08B}; // add
        tbl[1]  = '{32'h00430822, 1'b0, 1'b1, 6'd2, 2'b00, 9'h08B}; // sub
        tbl[2]  = '{32'h8C220004, 1'b0, 1'b1, 6'd1, 2'b01, 9'h08B}; // lw
        tbl[3]  = '{32'hAC220004, 1'b1, 1'b1, 6'd1, 2'b10, 9'h00B}; // sw
        tbl[4]  = '{32'h10220003, 1'b1, 1'b1, 6'd2, 2'b00, 9'h00F}; // beq taken
        tbl[5]  = '{32'h10220003, 1'b0, 1'b1, 6'd2, 2'b00, 9'h00B}; // beq not taken
        tbl[6]  = '{32'h14220003, 1'b0, 1'b1, 6'd2, 2'b00, 9'h00F}; // bne taken
        tbl[7]  = '{32'h14220003, 1'b1, 1'b1, 6'd2, 2'b00, 9'h00B}; // bne not taken
        tbl[8]  = '{32'h0C000010, 1'b0, 1'b0, 6'd0, 2'b00, 9'h083}; // jal
        tbl[9]  = '{32'hFC000000, 1'b1, 1'b1, 6'd0, 2'b00, 9'h00B}; // unknown opcode
        tbl[10] = '{32'h03E00008, 1'b0, 1'b0, 6'd0, 2'b00, 9'h009}; // jr
        tbl[11] = '{32'h6C000000, 1'b0, 1'b0, 6'd0, 2'b10, 9'h10B}; // push
        tbl[12] = '{32'h70000000, 1'b0, 1'b0, 6'd0, 2'b01, 9'h18B}; // pop
        tbl[13] = '{32'h08000010, 1'b1, 1'b0, 6'd0, 2'b00, 9'h003}; // jmp
        tbl[14] = '{32'h2822000A, 1'b0, 1'b1, 6'd9, 2'b00, 9'h08B}; // slti
        tbl[15] = '{32'h0000003F, 1'b0, 1'b1, 6'd0, 2'b00, 9'h00B}; // unknown funct

        // Reset held for three cycles, then released: one IDLE cycle, then FETCH.
        repeat (3) begin
            @(posedge CLK); #1;
            check_phase(0, 32'h0, 1'b0);
        end
        @(negedge CLK); RST = 1'b0;
        #1 check_phase(0, 32'h0, 1'b0);
        @(posedge CLK); #1;

        foreach (tbl[i]) begin
            run_instr(tbl[i].ins, tbl[i].z);
            if (tbl[i].chk_alu)
                check($sformatf("tbl%0d alu", i), {26'h0, obs[3][19:14]}, {26'h0, tbl[i].alu}, 32'h3F);
            check($sformatf("tbl%0d mem", i), {30'h0, obs[4][30:29]}, {30'h0, tbl[i].mem}, 32'h3);
            check($sformatf("tbl%0d wb", i), {23'h0, obs[5][8:0]}, {23'h0, tbl[i].wb}, 32'h1FF);
        end

        for (int k = 0; k < 150; k++) begin
            r = $urandom;
            case ($urandom_range(0, 2))
                0: ins = r;
                1: ins = {6'h00, r[25:6], rfun[$urandom_range(0, 9)]};
                default: ins = {iop[$urandom_range(0, 13)], r[25:0]};
            endcase
            run_instr(ins, 1'($urandom_range(0, 1)));
        end

        // Reset asserted mid-EXECUTE must clear outputs before any clock edge.
        INSTRUCTION = $urandom;
        @(posedge CLK); #1 INSTRUCTION = 32'h00430820;
        @(posedge CLK); #1 check_phase(3, 32'h00430820, 1'b0);
        #2 RST = 1'b1;
        #1 check_phase(0, 32'h0, 1'b0);
        @(posedge CLK); #1 check_phase(0, 32'h0, 1'b0);
        @(negedge CLK); RST = 1'b0;
        #1 check_phase(0, 32'h0, 1'b0);
        @(posedge CLK); #1;
        run_instr(32'h8C220004, 1'b0);
        run_instr(32'h00430820, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Multi-cycle control FSM that drives the processor data path.
- Consumes INSTRUCTION (the IR contents) and ZERO from the data path.
- Produces the CTRL bus that steers the data path's PC, IR, register-file, ALU and memory-address muxes, plus the memory READ/WRITE strobes.
- Every instruction takes a fixed five-state sequence.

Parameters:
- CTRL_W, 32, width of the CTRL bus
- OPRN_W, 6, width of the ALU operation field

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous, active-high reset
- INSTRUCTION  in  32  IR contents: opcode[31:26], funct[5:0]
- ZERO  in  1  ALU zero flag
- CTRL  out  32  data-path control bus (bit map below)
- READ  out  1  memory read strobe
- WRITE  out  1  memory write strobe

Behaviour:
- CTRL bit map:
  - 0 pc_load; 1 pc_sel_1 (1 = PC+1, 0 = rs data); 2 pc_sel_2 (1 = branch target); 3 pc_sel_3 (0 = jump address)
  - 4 ir_load; 5 r1_sel_1 (1 = SP as read address); 6 reg_r; 7 reg_w; 8 sp_load
  - 9 op1_sel_1; 10–13 op2_sel_1..4; 19:14 alu_oprn
  - 20 ma_sel_1; 21 ma_sel_2 (1 = PC as address); 22 md_sel_1; 23–25 wd_sel_1..3; 26–28 wa_sel_1..3
  - 29 mem_r; 30 mem_w; 31 reserved, always 0
- READ = CTRL[29]; WRITE = CTRL[30]. READ and WRITE are never both 1.
- alu_oprn codes: add 1, sub 2, mul 3, srl 4, sll 5, and 6, or 7, nor 8, slt 9.
- States: IDLE → FETCH → DECODE → EXECUTE → MEMORY → WRITEBACK → FETCH. One state per clock; 5 cycles per instruction.
- Outputs are a Moore decode of the state register plus INSTRUCTION. ZERO is used in WRITEBACK only.
- RST=1: state goes to IDLE immediately (asynchronous). CTRL=0, READ=0, WRITE=0 while in IDLE. The first rising edge with RST=0 enters FETCH.
- FETCH: mem_r=1, ma_sel_2=1, ir_load=1. IR captures memory data on the edge that leaves FETCH.
- DECODE: reg_r=1. r1_sel_1=1 only for pop (0x1c). All other bits 0.
- EXECUTE: alu_oprn and operand selects per instruction.
  - R-type (opcode 0) funct: add 0x20, sub 0x22, mul 0x2c, and 0x24, or 0x25, nor 0x27, slt 0x2a, sll 0x01, srl 0x02, jr 0x08.
  - I-type: addi 0x08, muli 0x1d, andi 0x0c, ori 0x0d, lui 0x0f, slti 0x0a, beq 0x04 (sub), bne 0x05 (sub), lw 0x23 (add), sw 0x2b (add).
  - J-type: jmp 0x02, jal 0x03, push 0x1b, pop 0x1c.
- MEMORY and WRITEBACK hold the EXECUTE operand and alu_oprn fields unchanged.
- MEMORY:
  - lw/pop: mem_r=1.
  - sw/push: mem_w=1, md_sel_1 set.
  - All others: mem_r=mem_w=0.
- WRITEBACK:
  - pc_load=1 for every opcode.
  - reg_w=1 for ALU ops, lw, pop and jal (jal writes r31 via wa_sel).
  - sp_load=1 for push/pop.
  - Next PC:
    - default: sel1=1, sel2=0, sel3=1
    - jr: sel1=0, sel2=0, sel3=1
    - beq with ZERO=1, or bne with ZERO=0: sel2=1, sel3=1
    - jmp/jal: sel3=0
- Unknown opcode or funct: NOP, i.e. WRITEBACK asserts only pc_load with the PC+1 selects. No register or memory write.
- INSTRUCTION changing outside the FETCH→DECODE edge has no effect on state sequencing.

Test Plan:
- Reset: hold RST=1 for 3 cycles, release → CTRL=0 and READ=WRITE=0 during reset; next cycle FETCH with CTRL[29]=1, CTRL[21]=1, CTRL[4]=1, READ=1.
- add (INSTRUCTION=0x00430820) → EXECUTE alu_oprn=1; WRITEBACK reg_w=1, pc_load=1, pc_sel_1=1, pc_sel_3=1; FETCH recurs exactly 5 cycles after the previous FETCH.
- lw (0x8C220004) → MEMORY READ=1, WRITE=0; WRITEBACK reg_w=1. sw (0xAC220004) → MEMORY WRITE=1, READ=0, reg_w=0 throughout.
- beq (0x10220003):
  - ZERO=1 → WRITEBACK pc_sel_2=1.
  - ZERO=0 → pc_sel_2=0.
  - bne with ZERO=0 → pc_sel_2=1.
- jal (0x0C000010) → WRITEBACK pc_sel_3=0, reg_w=1, pc_load=1. Unknown opcode 0x3F → only pc_load set in WRITEBACK.
- Assert RST mid-EXECUTE → outputs 0 in the same cycle without waiting for an edge; after release, sequence restarts at FETCH.
